// File: rtl/sort4_ctrl.sv
// Four-element, 4-bit bubble sorter sharing one magnitude comparator across all
// compare steps, with early exit when a pass makes no swaps.
module comparator_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic       EQ,
    output logic       GT,
    output logic       LT
);
    assign EQ = (a == b);
    assign GT = (a > b);
    assign LT = (a < b);
endmodule

module sort4_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        ascending,
    input  logic [15:0] din,
    output logic        busy,
    output logic        done,
    output logic [15:0] dout,
    output logic [2:0]  swap_cnt
);
    typedef enum logic [1:0] {IDLE, CMP, DONE} state_t;

    state_t           state_q, state_d;
    logic [3:0][3:0]  r_q, r_d;
    logic             asc_q, asc_d;
    logic [1:0]       idx_q, idx_d;
    logic [1:0]       pass_q, pass_d;
    logic [2:0]       cnt_q, cnt_d;
    logic             pswp_q, pswp_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [15:0]      dout_q, dout_d;
    logic [2:0]       swap_cnt_q, swap_cnt_d;

    logic [3:0] cmp_a, cmp_b;
    logic       eq, gt, lt;
    logic       do_swap, last_idx, swp_any;

    assign cmp_a = r_q[idx_q];
    assign cmp_b = r_q[idx_q + 2'd1];

    comparator_4bit u_cmp (
        .a  (cmp_a),
        .b  (cmp_b),
        .EQ (eq),
        .GT (gt),
        .LT (lt)
    );

    // Equal elements never swap, which keeps the sort stable.
    assign do_swap  = ~eq & ((asc_q & gt) | (~asc_q & lt));
    assign last_idx = (idx_q == (2'd2 - pass_q));
    assign swp_any  = pswp_q | do_swap;

    always_comb begin
        state_d    = state_q;
        r_d        = r_q;
        asc_d      = asc_q;
        idx_d      = idx_q;
        pass_d     = pass_q;
        cnt_d      = cnt_q;
        pswp_d     = pswp_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        dout_d     = dout_q;
        swap_cnt_d = swap_cnt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    r_d     = din;
                    asc_d   = ascending;
                    idx_d   = 2'd0;
                    pass_d  = 2'd0;
                    cnt_d   = 3'd0;
                    pswp_d  = 1'b0;
                    busy_d  = 1'b1;
                    state_d = CMP;
                end
            end
            CMP: begin
                if (do_swap) begin
                    r_d[idx_q]        = cmp_b;
                    r_d[idx_q + 2'd1] = cmp_a;
                    cnt_d             = cnt_q + 3'd1;
                end
                if (last_idx) begin
                    idx_d  = 2'd0;
                    pass_d = pass_q + 2'd1;
                    pswp_d = 1'b0;
                    // A clean pass means the array is already ordered.
                    if (!swp_any || pass_q == 2'd2)
                        state_d = DONE;
                end else begin
                    idx_d  = idx_q + 2'd1;
                    pswp_d = swp_any;
                end
            end
            DONE: begin
                dout_d     = r_q;
                swap_cnt_d = cnt_q;
                done_d     = 1'b1;
                busy_d     = 1'b0;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            r_q        <= '0;
            asc_q      <= 1'b0;
            idx_q      <= 2'd0;
            pass_q     <= 2'd0;
            cnt_q      <= 3'd0;
            pswp_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            dout_q     <= 16'h0000;
            swap_cnt_q <= 3'd0;
        end else begin
            state_q    <= state_d;
            r_q        <= r_d;
            asc_q      <= asc_d;
            idx_q      <= idx_d;
            pass_q     <= pass_d;
            cnt_q      <= cnt_d;
            pswp_q     <= pswp_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            dout_q     <= dout_d;
            swap_cnt_q <= swap_cnt_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign dout     = dout_q;
    assign swap_cnt = swap_cnt_q;
endmodule

// File: tb/tb_sort4_ctrl.sv
// Bench for sort4_ctrl: directed vectors, random sorts against an array-based
// reference, busy-ignore, mid-sort reset and back-to-back starts.
module tb_sort4_ctrl;
    logic        clk;
    logic        rst_n;
    logic        start;
    logic        ascending;
    logic [15:0] din;
    logic        busy;
    logic        done;
    logic [15:0] dout;
    logic [2:0]  swap_cnt;

    int vectors;
    int miscompares;

    sort4_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .ascending (ascending),
        .din       (din),
        .busy      (busy),
        .done      (done),
        .dout      (dout),
        .swap_cnt  (swap_cnt)
    );

    always #5 clk = ~clk;

    // Result is a plain sort, swap count is the number of strict inversions,
    // compare count follows the pass structure with early exit.
    function automatic void model(input logic [15:0] d_in, input bit asc,
                                  output logic [15:0] d_out, output int cnt, output int m);
        int e[4];
        int s[4];
        int t;
        bit sw;
        for (int i = 0; i < 4; i++) e[i] = int'(d_in[4*i +: 4]);
        cnt = 0;
        for (int i = 0; i < 4; i++)
            for (int j = i + 1; j < 4; j++)
                if (asc ? (e[i] > e[j]) : (e[i] < e[j])) cnt++;
        s = e;
        for (int i = 0; i < 4; i++)
            for (int j = i + 1; j < 4; j++)
                if (asc ? (s[j] < s[i]) : (s[j] > s[i])) begin
                    t = s[i]; s[i] = s[j]; s[j] = t;
                end
        d_out = '0;
        for (int i = 0; i < 4; i++) d_out[4*i +: 4] = 4'(s[i]);
        m = 0;
        for (int p = 0; p < 3; p++) begin
            sw = 0;
            for (int k = 0; k <= 2 - p; k++) begin
                m++;
                if (asc ? (e[k] > e[k+1]) : (e[k] < e[k+1])) begin
                    t = e[k]; e[k] = e[k+1]; e[k+1] = t; sw = 1;
                end
            end
            if (!sw) break;
        end
    endfunction

    // Drives one sort, scrambles inputs after the sample edge, and reports
    // latency, result and whether outputs stayed put until done.
    task automatic do_sort(input logic [15:0] d_in, input bit asc, output int lat,
                           output logic [15:0] d_o, output logic [2:0] c_o, output bit held);
        logic [15:0] prev_d;
        logic [2:0]  prev_c;
        prev_d = dout;
        prev_c = swap_cnt;
        held   = 1;
        lat    = -1;
        @(negedge clk);
        start = 1; din = d_in; ascending = asc;
        @(negedge clk);
        start = 0; din = 16'($urandom); ascending = 1'($urandom);
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (done) begin lat = i; break; end
            if (dout !== prev_d || swap_cnt !== prev_c) held = 0;
        end
        d_o = dout;
        c_o = swap_cnt;
    endtask

    task automatic test_reset;
        rst_n = 0; start = 0; din = 16'hFFFF; ascending = 1;
        repeat (2) @(negedge clk);
        vectors++;
        if ({busy, done, dout, swap_cnt} !== 21'h0) begin
            miscompares++;
            $display("FAIL reset_state: got busy=%b done=%b dout=%h cnt=%0d, want all zero",
                     busy, done, dout, swap_cnt);
        end
        rst_n = 1;
        repeat (3) @(negedge clk);
        vectors++;
        if ({busy, done, dout, swap_cnt} !== 21'h0) begin
            miscompares++;
            $display("FAIL reset_hold: got busy=%b done=%b dout=%h cnt=%0d, want all zero",
                     busy, done, dout, swap_cnt);
        end
    endtask

    task automatic test_vectors;
        logic [15:0] tv_din [5]  = '{16'h1935, 16'hFA41, 16'h4321, 16'h7777, 16'h7777};
        bit          tv_asc [5]  = '{1, 1, 0, 1, 0};
        logic [15:0] tv_dout[5]  = '{16'h9531, 16'hFA41, 16'h1234, 16'h7777, 16'h7777};
        int          tv_cnt [5]  = '{4, 0, 6, 0, 0};
        int          tv_lat [5]  = '{7, 4, 7, 4, 4};
        int lat; logic [15:0] d; logic [2:0] c; bit held;
        for (int i = 0; i < 5; i++) begin
            do_sort(tv_din[i], tv_asc[i], lat, d, c, held);
            vectors++;
            if (lat != tv_lat[i] || d !== tv_dout[i] || int'(c) != tv_cnt[i] || !held) begin
                miscompares++;
                $display("FAIL vec_%h_%0d: got lat=%0d dout=%h cnt=%0d held=%0d, want lat=%0d dout=%h cnt=%0d held=1",
                         tv_din[i], tv_asc[i], lat, d, c, held, tv_lat[i], tv_dout[i], tv_cnt[i]);
            end
            @(negedge clk);
            vectors++;
            if (done !== 1'b0 || busy !== 1'b0 || dout !== tv_dout[i]) begin
                miscompares++;
                $display("FAIL done_pulse: got done=%b busy=%b dout=%h, want done=0 busy=0 dout=%h",
                         done, busy, dout, tv_dout[i]);
            end
        end
    endtask

    task automatic test_random;
        logic [15:0] rd, ed, d;
        bit ra, held;
        int ec, em, lat;
        logic [2:0] c;
        for (int n = 0; n < 40; n++) begin
            rd = 16'($urandom);
            ra = 1'($urandom);
            model(rd, ra, ed, ec, em);
            do_sort(rd, ra, lat, d, c, held);
            vectors++;
            if (lat != em + 1 || d !== ed || int'(c) != ec || !held) begin
                miscompares++;
                $display("FAIL random_%h_%0d: got lat=%0d dout=%h cnt=%0d held=%0d, want lat=%0d dout=%h cnt=%0d held=1",
                         rd, ra, lat, d, c, held, em + 1, ed, ec);
            end
        end
    endtask

    task automatic test_busy_ignore;
        int lat;
        @(negedge clk);
        start = 1; din = 16'h1935; ascending = 1;
        @(negedge clk);
        din = 16'h4321; ascending = 0;
        repeat (4) @(negedge clk);
        start = 0;
        lat = -1;
        for (int i = 5; i <= 20; i++) begin
            @(negedge clk);
            if (done) begin lat = i; break; end
        end
        vectors++;
        if (lat != 7 || dout !== 16'h9531 || swap_cnt !== 3'd4) begin
            miscompares++;
            $display("FAIL busy_ignore: got lat=%0d dout=%h cnt=%0d, want lat=7 dout=9531 cnt=4",
                     lat, dout, swap_cnt);
        end
    endtask

    task automatic test_reset_mid;
        bit seen;
        @(negedge clk);
        start = 1; din = 16'h1935; ascending = 1;
        @(negedge clk);
        start = 0;
        repeat (2) @(negedge clk);
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_busy: got busy=%b, want 1", busy);
        end
        rst_n = 0; start = 1;
        @(negedge clk);
        vectors++;
        if ({busy, done, dout, swap_cnt} !== 21'h0) begin
            miscompares++;
            $display("FAIL mid_reset: got busy=%b done=%b dout=%h cnt=%0d, want all zero",
                     busy, done, dout, swap_cnt);
        end
        @(negedge clk);
        rst_n = 1; start = 0;
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (done || busy || dout !== 16'h0) seen = 1;
        end
        vectors++;
        if (seen) begin
            miscompares++;
            $display("FAIL mid_discard: got activity after reset, want none (dout=%h)", dout);
        end
    endtask

    task automatic test_back_to_back;
        int lat;
        bit held;
        @(negedge clk);
        start = 1; din = 16'h1935; ascending = 1;
        @(negedge clk);
        din = 16'h4321; ascending = 0;
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (done) begin lat = i; break; end
        end
        vectors++;
        if (lat != 7 || dout !== 16'h9531 || swap_cnt !== 3'd4) begin
            miscompares++;
            $display("FAIL b2b_first: got lat=%0d dout=%h cnt=%0d, want lat=7 dout=9531 cnt=4",
                     lat, dout, swap_cnt);
        end
        @(negedge clk);
        vectors++;
        if (busy !== 1'b1 || done !== 1'b0 || dout !== 16'h9531) begin
            miscompares++;
            $display("FAIL b2b_restart: got busy=%b done=%b dout=%h, want busy=1 done=0 dout=9531",
                     busy, done, dout);
        end
        start = 0;
        lat = -1;
        held = 1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (done) begin lat = i; break; end
            if (dout !== 16'h9531 || swap_cnt !== 3'd4) held = 0;
        end
        vectors++;
        if (lat != 7 || dout !== 16'h1234 || swap_cnt !== 3'd6 || !held) begin
            miscompares++;
            $display("FAIL b2b_second: got lat=%0d dout=%h cnt=%0d held=%0d, want lat=7 dout=1234 cnt=6 held=1",
                     lat, dout, swap_cnt, held);
        end
    endtask

    initial begin
        clk = 0; rst_n = 0; start = 0; ascending = 1; din = 16'h0;
        vectors = 0; miscompares = 0;
        test_reset();
        test_vectors();
        test_random();
        test_busy_ignore();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
